// File: rtl/fft_pkg.sv
// Shared FSM encoding and frame-length helper for the FFT input framer.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  // Frame length in samples for a given index width.
  function automatic int unsigned FFT_LEN(input int unsigned addr_width);
    return 32'd1 << (addr_width + 1);
  endfunction

endpackage

// File: rtl/fft_axis_reg.sv
// One-stage valid/ready output register carrying data, user and last.
// Full throughput: a new word may load in the same cycle the held one drains.
module fft_axis_reg #(
  parameter int DW = 32,
  parameter int UW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [UW-1:0] in_user,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [UW-1:0] out_user,
  output logic          out_last
);

  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_user  <= '0;
      out_last  <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_user  <= in_user;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fft_frame_gen.sv
// Frames a sample stream into fixed-length FFT input frames, tagging each sample
// with its index and flagging the last one; one cycle latency, stalls the source.
module fft_frame_gen
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fft_start,
  input  logic                    src_valid,
  output logic                    src_ready,
  input  logic [2*DATA_WIDTH-1:0] src_data,
  output logic                    s_axi_valid,
  input  logic                    s_axi_ready,
  output logic [2*DATA_WIDTH-1:0] s_axi_data,
  output logic                    s_axi_last,
  output logic [ADDR_WIDTH:0]     s_axi_user,
  output logic                    busy,
  output logic                    start_err,
  output logic [15:0]             frame_cnt
);

  localparam int unsigned            N        = FFT_LEN(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]    LAST_IDX = (ADDR_WIDTH + 1)'(N - 1);

  state_t              state;
  logic [ADDR_WIDTH:0] cnt;
  logic                reg_ready;
  logic                accept;
  logic                last_hs;

  assign src_ready = (state == ACTIVE) & reg_ready;
  assign accept    = src_valid & src_ready;
  assign last_hs   = s_axi_valid & s_axi_ready & s_axi_last;
  assign busy      = (state != IDLE);

  fft_axis_reg #(
    .DW(2 * DATA_WIDTH),
    .UW(ADDR_WIDTH + 1)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (accept),
    .in_ready (reg_ready),
    .in_data  (src_data),
    .in_user  (cnt),
    .in_last  (cnt == LAST_IDX),
    .out_valid(s_axi_valid),
    .out_ready(s_axi_ready),
    .out_data (s_axi_data),
    .out_user (s_axi_user),
    .out_last (s_axi_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      start_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      start_err <= 1'b0;
      case (state)
        IDLE: begin
          if (fft_start) begin
            state <= ACTIVE;
            cnt   <= '0;
          end
        end
        ACTIVE: begin
          if (fft_start) start_err <= 1'b1;
          // The counter stops at the last index so it never wraps inside a frame.
          if (accept) begin
            if (cnt == LAST_IDX) state <= FLUSH;
            else                 cnt   <= cnt + 1'b1;
          end
        end
        FLUSH: begin
          if (last_hs) begin
            frame_cnt <= frame_cnt + 16'd1;
            if (fft_start) begin
              state <= ACTIVE;
              cnt   <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (fft_start) begin
            start_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_gen.sv
// Directed bench for fft_frame_gen with N=8 frames.
module tb_fft_frame_gen;

  localparam int DW = 16;
  localparam int AW = 2;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fft_start = 1'b0;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic [31:0]   src_data = '0;
  logic          s_axi_valid;
  logic          s_axi_ready = 1'b0;
  logic [31:0]   s_axi_data;
  logic          s_axi_last;
  logic [AW:0]   s_axi_user;
  logic          busy;
  logic          start_err;
  logic [15:0]   frame_cnt;

  int tests = 0;
  int fails = 0;
  int ftag  = 1;

  always #5 clk = ~clk;

  fft_frame_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fft_start  (fft_start),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_data   (src_data),
    .s_axi_valid(s_axi_valid),
    .s_axi_ready(s_axi_ready),
    .s_axi_data (s_axi_data),
    .s_axi_last (s_axi_last),
    .s_axi_user (s_axi_user),
    .busy       (busy),
    .start_err  (start_err),
    .frame_cnt  (frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input int f, input int k);
    logic [15:0] v;
    v = 16'(f * 16 + k);
    return {v, ~v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    fft_start = 1'b1;
    tick();
    fft_start = 1'b0;
  endtask

  // Drives one frame from the ACTIVE state; called just after a rising edge.
  task automatic stream(input logic [31:0] rdy_pat, input int start_at, input bit err_exp);
    int acc = 0;
    int out_n = 0;
    int cyc = 0;
    bit pend = 1'b0;
    bit exp_rdy;
    while (out_n < N) begin
      if (cyc >= 64) begin
        check("stream_timeout", out_n, N);
        break;
      end
      s_axi_ready = rdy_pat[cyc % 32];
      src_valid   = (acc < N);
      src_data    = mk(ftag, acc);
      fft_start   = (cyc == start_at);
      @(negedge clk);
      exp_rdy = (acc < N) && (!pend || s_axi_ready);
      check("src_ready", src_ready, exp_rdy);
      check("busy", busy, 1);
      check("s_axi_valid", s_axi_valid, pend);
      if (pend) begin
        check("user", s_axi_user, out_n);
        check("data", s_axi_data, mk(ftag, out_n));
        check("last", s_axi_last, out_n == N - 1);
      end
      check("start_err", start_err, err_exp && (cyc == start_at + 1));
      if (pend && s_axi_ready) begin
        out_n++;
        pend = 1'b0;
      end
      if (exp_rdy) begin
        acc++;
        pend = 1'b1;
      end
      tick();
      cyc++;
    end
    fft_start = 1'b0;
    src_valid = 1'b0;
    ftag++;
  endtask

  task automatic check_idle(input logic [15:0] exp_fc);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_valid", s_axi_valid, 0);
    check("idle_src_ready", src_ready, 0);
    check("idle_start_err", start_err, 0);
    check("frame_cnt", frame_cnt, exp_fc);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, s_axi_valid, 0);
    check({tag, "_last"}, s_axi_last, 0);
    check({tag, "_user"}, s_axi_user, 0);
    check({tag, "_data"}, s_axi_data, 0);
    check({tag, "_src_ready"}, src_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_start_err"}, start_err, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
  endtask

  initial begin
    // Reset state, with the source and sink both offering to transfer.
    src_valid   = 1'b1;
    s_axi_ready = 1'b1;
    #2;
    check_all_zero("rst");
    tick();
    src_valid = 1'b0;
    rst_n     = 1'b1;
    tick();

    // Full-rate frame.
    start_frame();
    stream(32'hFFFF_FFFF, -10, 1'b0);
    check_idle(16'd1);

    // Reset after index 4 is accepted discards the partial frame.
    start_frame();
    src_valid   = 1'b1;
    s_axi_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      src_data = mk(ftag, k);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    src_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    ftag++;

    // Fresh frame ending with a start on the last handshake.
    start_frame();
    stream(32'hFFFF_FFFF, 8, 1'b0);
    @(negedge clk);
    check("b2b_busy", busy, 1);
    check("b2b_start_err", start_err, 0);
    check("b2b_frame_cnt", frame_cnt, 1);
    check("b2b_valid", s_axi_valid, 0);
    check("b2b_src_ready", src_ready, 1);
    tick();
    stream(32'hFFFF_FFFF, -10, 1'b0);
    check_idle(16'd2);

    // Sink ready toggling 1010...
    start_frame();
    stream(32'h5555_5555, -10, 1'b0);
    check_idle(16'd3);

    // Stray start while active.
    start_frame();
    stream(32'hFFFF_FFFF, 3, 1'b1);
    check_idle(16'd4);

    // Frame counter wrap.
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    #1;
    check("preload", frame_cnt, 16'hFFFF);
    tick();
    start_frame();
    stream(32'hFFFF_FFFF, -10, 1'b0);
    check_idle(16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
